// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss handler. It stalls the core, streams one block of
// 16-bit words from multi-cycle memory into the data array, and writes the tag
// entry in the same cycle as the last data word.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no fill in flight; a miss latches the block base and stalls the core
// FILL  | issuing word reads and accepting returned words until the block is full
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       miss_detected,
    input  logic [ADDR_W-1:0]          miss_address,
    input  logic                       memory_data_valid,
    input  logic [15:0]                memory_data,
    output logic                       fsm_busy,
    output logic                       mem_read_en,
    output logic [ADDR_W-1:0]          memory_address,
    output logic                       write_data_array,
    output logic [WORDS_PER_BLOCK-1:0] word_sel,
    output logic [15:0]                fill_data,
    output logic                       write_tag_array
);

    // Word index bits, byte offset bits within a block, and counter width
    // (the counters must be able to hold WORDS_PER_BLOCK itself).
    localparam int IDXW = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int OFFW = IDXW + 1;
    localparam int CNTW = IDXW + 1;

    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WORDS_PER_BLOCK);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WORDS_PER_BLOCK - 1);
    localparam logic [WORDS_PER_BLOCK-1:0] SEL_ONE = {{(WORDS_PER_BLOCK-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                   state;
    logic [CNTW-1:0]          issue_cnt;
    logic [CNTW-1:0]          recv_cnt;
    // Only the block-aligned part of the address is kept; the word offset
    // comes from issue_cnt, so the request address can never carry out of
    // the block.
    logic [ADDR_W-OFFW-1:0]   base_tag;

    logic in_fill;
    logic issuing;
    logic taking;
    logic last_word;

    // Decode of the registered state plus current memory inputs.
    always_comb begin
        in_fill   = (state == FILL);
        issuing   = in_fill && (issue_cnt < CNT_FULL);
        taking    = in_fill && memory_data_valid;
        last_word = taking && (recv_cnt == CNT_LAST);
    end

    // State, counters and latched block base.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            base_tag  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base_tag  <= miss_address[ADDR_W-1:OFFW];
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (issuing)
                        issue_cnt <= issue_cnt + 1'b1;
                    if (taking)
                        recv_cnt <= recv_cnt + 1'b1;
                    if (last_word)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode. The stall is combinational on miss_detected so the core
    // freezes in the miss cycle itself; everything else follows the registers
    // and the current memory return only.
    always_comb begin
        fsm_busy         = in_fill || (miss_detected && !rst);
        mem_read_en      = issuing;
        memory_address   = issuing ? {base_tag, issue_cnt[IDXW-1:0], 1'b0} : '0;
        write_data_array = taking;
        word_sel         = taking ? (SEL_ONE << recv_cnt[IDXW-1:0]) : '0;
        fill_data        = taking ? memory_data : '0;
        write_tag_array  = last_word;
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Testbench for cache_fill_fsm: directed fills against a small memory model,
// with expected read addresses and data-array writes held in scoreboard queues.
module tb_cache_fill_fsm;

    localparam int MEM_LAT = 4;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [7:0]  word_sel;
    logic [15:0] fill_data;
    logic        write_tag_array;

    cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .word_sel          (word_sel),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int due; logic [15:0] data; } pend_t;
    typedef struct { logic [7:0] sel; logic [15:0] data; } wr_t;

    pend_t       pend[$];
    wr_t         exp_wr_q[$];
    logic [15:0] exp_addr_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    int issue_k  = 0;
    int wr_seen  = 0;
    int tag_seen = 0;
    int wr0, tag0;
    bit use_sched = 0;
    int sched[8] = '{5, 7, 8, 11, 12, 14, 15, 20};
    logic [15:0] last_addr;

    logic        s_busy, s_rd, s_wr, s_tag;
    logic [15:0] s_addr, s_fd;
    logic [7:0]  s_sel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc - t0, obs, exp);
        end
    endtask

    // Word the memory model returns for a byte address (0xA000+i for block 0x1230).
    function automatic logic [15:0] dfun(input logic [15:0] a);
        logic [15:0] w;
        w = 16'hA000 + {13'd0, a[3:1]};
        return w ^ {a[15:8] ^ 8'h12, 8'h00};
    endfunction

    task automatic expect_fill(input logic [15:0] base);
        wr_t         e;
        logic [7:0]  s;
        logic [15:0] a;
        issue_k = 0;
        for (int i = 0; i < 8; i++) begin
            a = base + 16'(2 * i);
            s = 8'b1 << i;
            exp_addr_q.push_back(a);
            e.sel  = s;
            e.data = dfun(a);
            exp_wr_q.push_back(e);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, sample and
    // score the outputs at the falling edge.
    task automatic tick(input logic miss, input logic [15:0] maddr, input bit stray, input bit rst_mid);
        logic        v;
        logic [15:0] d;
        logic [15:0] a;
        pend_t       p;
        wr_t         e;
        miss_detected = miss;
        miss_address  = maddr;
        v = 1'b0;
        d = 16'h0000;
        if (stray) begin
            v = 1'b1;
            d = 16'hDEAD;
        end else if (pend.size() > 0 && pend[0].due == cyc) begin
            v = 1'b1;
            d = pend[0].data;
            void'(pend.pop_front());
        end
        memory_data_valid = v;
        memory_data       = d;
        @(negedge clk);
        s_busy = fsm_busy;
        s_rd   = mem_read_en;
        s_addr = memory_address;
        s_wr   = write_data_array;
        s_sel  = word_sel;
        s_fd   = fill_data;
        s_tag  = write_tag_array;
        if (s_rd) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_read", {48'd0, s_addr}, 64'hFFFF_FFFF);
                a = s_addr;
            end else begin
                a = exp_addr_q.pop_front();
                check("read_addr", {48'd0, s_addr}, {48'd0, a});
            end
            last_addr = s_addr;
            p.due  = (use_sched && issue_k < 8) ? t0 + sched[issue_k] : cyc + MEM_LAT;
            p.data = dfun(a);
            pend.push_back(p);
            issue_k++;
        end
        if (s_wr) begin
            wr_seen++;
            check("write_needs_valid", {63'd0, v}, 64'd1);
            if (exp_wr_q.size() == 0) begin
                check("unexpected_write", {56'd0, s_sel}, 64'd0);
            end else begin
                e = exp_wr_q.pop_front();
                check("word_sel", {56'd0, s_sel}, {56'd0, e.sel});
                check("fill_data", {48'd0, s_fd}, {48'd0, e.data});
            end
        end
        if (s_tag) begin
            tag_seen++;
            check("tag_with_last_word", {62'd0, s_wr, exp_wr_q.size() == 0}, 64'd3);
        end
        if (rst_mid) begin
            rst = 1'b1;
            #1;
            check("outputs_in_reset", {20'd0, fsm_busy, mem_read_en, memory_address, write_data_array,
                                       word_sel, fill_data, write_tag_array}, 64'd0);
            exp_addr_q.delete();
            exp_wr_q.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b1;
        miss_detected = 1'b0;
        miss_address = 16'h0000;
        memory_data_valid = 1'b0;
        memory_data = 16'h0000;
        last_addr = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {20'd0, fsm_busy, mem_read_en, memory_address, write_data_array,
                                word_sel, fill_data, write_tag_array}, 64'd0);
        rst = 1'b0;
        tick(1'b0, 16'h0, 1'b0, 1'b0);
        check("idle_busy", {63'd0, s_busy}, 64'd0);

        // Basic fill with a miss pulse during the fill, then a back-to-back miss.
        t0 = cyc; wr0 = wr_seen; tag0 = tag_seen;
        expect_fill(16'h1230);
        tick(1'b1, 16'h1236, 1'b0, 1'b0);
        check("busy_in_miss_cycle", {63'd0, s_busy}, 64'd1);
        for (int i = 1; i <= 12; i++) begin
            tick(i == 6, (i == 6) ? 16'h4000 : 16'h0000, 1'b0, 1'b0);
            check("fill1_busy", {63'd0, s_busy}, 64'd1);
            check("fill1_tag_cycle", {63'd0, s_tag}, {63'd0, i == 12});
            if (i == 1) check("fill1_first_addr", {47'd0, s_rd, s_addr}, {47'd1, 16'h1230});
        end
        check("fill1_writes", wr_seen - wr0, 64'd8);
        check("fill1_tags", tag_seen - tag0, 64'd1);
        t0 = cyc; wr0 = wr_seen; tag0 = tag_seen;
        expect_fill(16'h2000);
        tick(1'b1, 16'h2000, 1'b0, 1'b0);
        check("b2b_busy", {62'd0, s_busy, s_rd}, 64'd2);
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 16'h0, 1'b0, 1'b0);
            if (i == 1) check("b2b_first_addr", {47'd0, s_rd, s_addr}, {47'd1, 16'h2000});
            check("fill2_tag_cycle", {63'd0, s_tag}, {63'd0, i == 12});
        end
        tick(1'b0, 16'h0, 1'b0, 1'b0);
        check("fill2_idle", {63'd0, s_busy}, 64'd0);
        check("fill2_writes", wr_seen - wr0, 64'd8);

        // Reset in the middle of a fill; late returns must be ignored.
        t0 = cyc; wr0 = wr_seen; tag0 = tag_seen;
        expect_fill(16'h3000);
        tick(1'b1, 16'h3004, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) tick(1'b0, 16'h0, 1'b0, i == 7);
        check("pre_reset_writes", wr_seen - wr0, 64'd3);
        tick(1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 9; i <= 12; i++) tick(1'b0, 16'h0, i == 12, 1'b0);
        check("post_reset_writes", wr_seen - wr0, 64'd3);
        check("post_reset_tags", tag_seen - tag0, 64'd0);
        check("post_reset_busy", {63'd0, s_busy}, 64'd0);
        check("late_returns_drained", pend.size(), 64'd0);
        pend.delete();

        // Stray valid in IDLE, then a fill at the top of memory.
        tick(1'b0, 16'h0, 1'b1, 1'b0);
        check("stray_no_write", {62'd0, s_wr, s_tag}, 64'd0);
        t0 = cyc; wr0 = wr_seen;
        expect_fill(16'hFFF0);
        tick(1'b1, 16'hFFFB, 1'b0, 1'b0);
        for (int i = 1; i <= 13; i++) begin
            tick(1'b0, 16'h0, 1'b0, 1'b0);
            if (i == 1) check("top_first_addr", {48'd0, s_addr}, 64'hFFF0);
        end
        check("top_last_addr", {48'd0, last_addr}, 64'hFFFE);
        check("top_idle", {63'd0, s_busy}, 64'd0);
        check("top_writes", wr_seen - wr0, 64'd8);

        // Variable memory latency with gaps between returns.
        use_sched = 1;
        t0 = cyc; wr0 = wr_seen; tag0 = tag_seen;
        expect_fill(16'h5A50);
        tick(1'b1, 16'h5A5A, 1'b0, 1'b0);
        for (int i = 1; i <= 21; i++) begin
            tick(1'b0, 16'h0, 1'b0, 1'b0);
            check("var_tag_cycle", {63'd0, s_tag}, {63'd0, i == 20});
            check("var_busy", {63'd0, s_busy}, {63'd0, i <= 20});
        end
        check("var_writes", wr_seen - wr0, 64'd8);
        check("var_tags", tag_seen - tag0, 64'd1);
        use_sched = 0;

        check("addr_queue_empty", exp_addr_q.size(), 64'd0);
        check("write_queue_empty", exp_wr_q.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss-handling controller between the CPU's cache arrays and the multi-cycle main memory.
- On a cache miss it stalls the core and streams the missing 16-byte block (8 × 16-bit words) from memory into the data array.
- Once the block is complete, it writes the tag array.
- It sits downstream of the CPU datapath's memory stage and upstream of the memory model.

Parameters:
- WORDS_PER_BLOCK, 8: 16-bit words per cache block. Block size in bytes is 2 × WORDS_PER_BLOCK.
- ADDR_W, 16: address width in bits.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- miss_detected  in  1  cache lookup missed this cycle.
- miss_address  in  ADDR_W  byte address that missed.
- memory_data_valid  in  1  memory_data carries a returned word this cycle.
- memory_data  in  16  word returned by memory.
- fsm_busy  out  1  stall request to the core.
- mem_read_en  out  1  memory read request this cycle.
- memory_address  out  ADDR_W  byte address of the current read request.
- write_data_array  out  1  write fill_data into the data array.
- word_sel  out  WORDS_PER_BLOCK  one-hot word index for the data array write.
- fill_data  out  16  word to write (equal to memory_data).
- write_tag_array  out  1  write the tag/valid entry for the latched block.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; issue_cnt=0; recv_cnt=0; base=0.
  - All outputs 0 (memory_address=0, word_sel=0).
- States: IDLE, FILL.
- IDLE:
  - fsm_busy = miss_detected (combinational, so the core stalls in the miss cycle itself).
  - If miss_detected: latch base = miss_address with low log2(2×WORDS_PER_BLOCK) bits cleared; clear both counters; next state FILL.
  - memory_data_valid is ignored in IDLE: no array writes.
- FILL:
  - fsm_busy=1.
  - Issue side:
    - mem_read_en = (issue_cnt < WORDS_PER_BLOCK).
    - memory_address = base + 2×issue_cnt, low bits only, no carry into tag bits.
    - issue_cnt increments on each cycle with mem_read_en=1 and saturates at WORDS_PER_BLOCK.
    - With no stalls, one request is issued every cycle.
  - Receive side:
    - On memory_data_valid: write_data_array=1, word_sel = one-hot(recv_cnt), fill_data=memory_data; recv_cnt increments.
    - Returned words are assumed to arrive in issue order.
  - The issue and receive sides are independent; issue and return may coincide in the same cycle.
  - Completion:
    - On the valid that brings recv_cnt to WORDS_PER_BLOCK−1 → WORDS_PER_BLOCK, write_tag_array=1 in that same cycle.
    - Next state is IDLE.
  - miss_detected is ignored while in FILL.
- Timing with 4-cycle memory:
  - Miss seen in cycle 0; requests in cycles 1–8; data in cycles 5–12.
  - Tag write in cycle 12; IDLE in cycle 13; fsm_busy high for 13 cycles.
  - A new miss_detected in cycle 13 starts the next fill immediately.
- Address boundary:
  - base 0xFFF0 issues 0xFFF0…0xFFFE.
  - The counter never carries past the block.
- Reset mid-FILL:
  - Immediate return to IDLE, counters cleared, no tag write.
  - Late memory_data_valid pulses after reset are ignored (IDLE rule).
- Outputs other than fsm_busy depend only on registered state/counters and current memory inputs. There is no combinational path from miss_address to memory_address.

Test Plan:
- Basic fill: miss_address=0x1236 in cycle 0, memory returns 0xA000+i at 4-cycle latency.
  - Expected: addresses 0x1230,0x1232,…,0x123E in cycles 1–8.
  - Expected: word_sel 0x01…0x80 with data 0xA000…0xA007 in cycles 5–12.
  - Expected: write_tag_array only in cycle 12; fsm_busy=0 from cycle 13.
- Miss during fill: pulse miss_detected with miss_address=0x4000 in cycle 6.
  - Expected: ignored; addresses stay 0x123x.
  - Expected: exactly 8 data writes and 1 tag write.
- Back-to-back misses: second miss 0x2000 asserted in cycle 13.
  - Expected: fsm_busy stays 1; requests to 0x2000 start in cycle 14.
- Reset mid-fill: assert rst in cycle 7 (after 3 data writes).
  - Expected: all outputs 0 immediately.
  - Expected: valids in cycles 8–12 produce no write_data_array or write_tag_array.
- Stray/top-of-memory case: memory_data_valid=1 in IDLE → no writes. Then miss_address=0xFFFB.
  - Expected: base 0xFFF0, last address 0xFFFE, no wrap to 0x0000.
- Variable latency: return words with gaps (valid in cycles 5,7,8,11,12,14,15,20).
  - Expected: word_sel increments only on valid; tag write in cycle 20; IDLE in cycle 21.
